lfsr_crypt_seq: RTL and testbench
=================================

Name: lfsr_crypt_seq

Overview:
- Hardware sequencer that drives the external 7-bit LFSR and the 256-byte data memory to encrypt or decrypt a message block without instruction-level control.
- It configures the LFSR taps and seed, then loops over the block: read byte, XOR with LFSR state, write byte, shift LFSR.
- Sits beside Ctrl. While busy it owns the LFSR control lines and the data-memory port. The top-level mux selects its memory signals whenever Busy=1.

Parameters:
- ADDR_W, 8, data-memory address width; address arithmetic wraps modulo 2^ADDR_W.
- PRE_LEN, 10, preamble byte count (used only with CRYPT_PREAMBLE_EN).
- PRE_CHAR, 8'h20, preamble plaintext byte (used only with CRYPT_PREAMBLE_EN).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request; sampled only in IDLE.
- CfgSeed  in  7  LFSR seed, latched on accepted Start.
- CfgTaps  in  7  LFSR tap pattern, latched on accepted Start.
- CfgSrc  in  8  source base address, latched.
- CfgDst  in  8  destination base address, latched.
- CfgLen  in  8  message byte count, latched; 0 is legal.
- MemGnt  in  1  memory port grant; low stalls the sequencer.
- MemRdData  in  8  read data, valid the cycle after the address is presented.
- LFSRState  in  7  current LFSR state.
- Busy  out  1  high from the cycle after an accepted Start through DONE.
- Done  out  1  one-cycle pulse at completion.
- LFSRSetState  out  1  load LFSR with LFSRSeedOut.
- LFSRSetTapPtrn  out  1  load LFSR taps with LFSRTapOut.
- LFSRShift  out  1  advance LFSR by one step.
- LFSRSeedOut  out  7  latched seed.
- LFSRTapOut  out  7  latched taps.
- MemAddr  out  8  memory address.
- MemWrEn  out  1  memory write strobe.
- MemWrData  out  8  write data.

Behaviour:
- Reset (async, Reset=0):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Config registers and index are cleared.
  - A reset mid-operation aborts with no further writes; memory already written is left as is.
- IDLE: Start=1 latches Cfg*, clears index i, and goes to CFG. Start is ignored in every other state.
- CFG (1 cycle): assert LFSRSetState and LFSRSetTapPtrn together. Next state is RD, or DONE if CfgLen=0.
- RD: MemAddr=Src+i.
  - If MemGnt=1, go to WAIT.
  - Otherwise hold RD with the address stable.
- WAIT: capture MemRdData into the data register, then go to WR.
- WR: MemAddr=Dst+i, MemWrData=data^{1'b0,LFSRState}.
  - If MemGnt=1: assert MemWrEn and LFSRShift for this cycle and increment i. Go to DONE if i+1==Len, else go to RD.
  - If MemGnt=0: hold WR with MemWrEn=0 and LFSRShift=0.
- DONE (1 cycle): Done=1, Busy=1; next state IDLE.
- Timing and strobes:
  - With MemGnt tied high, latency from accepted Start to Done is 2+3*Len cycles.
  - LFSRShift and MemWrEn occur only in the same cycle.
  - MemWrEn=0 outside WR.
- Arithmetic:
  - Src+i and Dst+i are 8-bit sums that wrap (0xFF+1 gives 0x00).
  - Len=255 processes 255 bytes.
  - Bit 7 of the data passes through unchanged.
- Overlapping Src/Dst: the block processes bytes in increasing order only. Src==Dst gives in-place operation.

Optional Feature:
- Macro: CRYPT_PREAMBLE_EN.
- Defined:
  - After CFG, the FSM enters state PRE for PRE_LEN bytes. Each byte needs one granted cycle.
  - Each PRE byte writes Dst+k = PRE_CHAR^{1'b0,LFSRState} with LFSRShift, for k=0..PRE_LEN-1.
  - After PRE, message bytes go to Dst+PRE_LEN+i.
  - Latency becomes 2+PRE_LEN+3*Len.
  - Len=0 still writes the preamble.
- Undefined: the PRE state and its logic are absent; PRE_LEN and PRE_CHAR are unused.

Test Plan:
- Basic run:
  - Stimulus: mem[0]=0x41, mem[1]=0x42, Seed=0x01, Taps=0x60, Src=0x00, Dst=0x40, Len=2, MemGnt=1.
  - Response: mem[0x40]=0x40, mem[0x41]=0x40; Done pulses at cycle 8 after Start; exactly 2 LFSRShift pulses.
- Zero length: Len=0 -> CFG then DONE; Done at cycle 2; no MemWrEn, no LFSRShift.
- Wrap: Src=0xFF, Dst=0xFE, Len=3 -> reads 0xFF, 0x00, 0x01; writes 0xFE, 0xFF, 0x00.
- Stall:
  - Stimulus: MemGnt low 4 cycles during RD of byte 1, then low 2 cycles in WR.
  - Response: MemAddr held stable; Done delayed by exactly 6 cycles; data correct.
- Reset and Start rules:
  - Reset=0 asserted in WR of byte 2 of Len=5 -> all outputs 0 immediately; only bytes 0-1 written.
  - Start during Busy -> ignored, Cfg unchanged.
- Preamble (CRYPT_PREAMBLE_EN, PRE_LEN=10): Len=1, Dst=0x40 -> mem[0x40..0x49] are the preamble bytes; message byte at 0x4A; 10+1 LFSRShift pulses.

Source files
------------

// File: rtl/lfsr_crypt_seq.sv
// Block-cipher sequencer: XORs a memory block with an external 7-bit LFSR stream.
// Define CRYPT_PREAMBLE_EN to emit PRE_LEN encrypted PRE_CHAR bytes ahead of the message.
module lfsr_crypt_seq #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned PRE_LEN  = 10,
    parameter logic [7:0]  PRE_CHAR = 8'h20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [6:0]        CfgSeed,
    input  logic [6:0]        CfgTaps,
    input  logic [ADDR_W-1:0] CfgSrc,
    input  logic [ADDR_W-1:0] CfgDst,
    input  logic [7:0]        CfgLen,
    input  logic              MemGnt,
    input  logic [7:0]        MemRdData,
    input  logic [6:0]        LFSRState,
    output logic              Busy,
    output logic              Done,
    output logic              LFSRSetState,
    output logic              LFSRSetTapPtrn,
    output logic              LFSRShift,
    output logic [6:0]        LFSRSeedOut,
    output logic [6:0]        LFSRTapOut,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWrEn,
    output logic [7:0]        MemWrData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
`ifdef CRYPT_PREAMBLE_EN
        S_PRE,
`endif
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [6:0]        r_seed;
    logic [6:0]        r_taps;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [7:0]        r_len;
    logic [7:0]        r_idx;
    logic [7:0]        r_data;
    logic [7:0]        w_idx_next;
    logic [ADDR_W-1:0] w_idx_a;
    logic [ADDR_W-1:0] w_msg_dst;

    assign w_idx_next = r_idx + 8'd1;
    assign w_idx_a    = ADDR_W'(r_idx);

`ifdef CRYPT_PREAMBLE_EN
    localparam logic [7:0] PRE_LAST = 8'(PRE_LEN - 1);
    logic [7:0] r_pre_k;

    // Message bytes land after the preamble.
    assign w_msg_dst = r_dst + ADDR_W'(PRE_LEN);
`else
    logic w_unused_pre;

    assign w_msg_dst    = r_dst;
    assign w_unused_pre = ^{PRE_CHAR, PRE_LEN};
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_seed  <= '0;
            r_taps  <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
`ifdef CRYPT_PREAMBLE_EN
            r_pre_k <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_seed  <= CfgSeed;
                        r_taps  <= CfgTaps;
                        r_src   <= CfgSrc;
                        r_dst   <= CfgDst;
                        r_len   <= CfgLen;
                        r_idx   <= '0;
                        r_state <= S_CFG;
                    end
                end
                S_CFG: begin
`ifdef CRYPT_PREAMBLE_EN
                    r_pre_k <= '0;
                    r_state <= S_PRE;
`else
                    r_state <= (r_len == 8'd0) ? S_DONE : S_RD;
`endif
                end
`ifdef CRYPT_PREAMBLE_EN
                S_PRE: begin
                    if (MemGnt) begin
                        r_pre_k <= r_pre_k + 8'd1;
                        if (r_pre_k == PRE_LAST) begin
                            r_state <= (r_len == 8'd0) ? S_DONE : S_RD;
                        end
                    end
                end
`endif
                S_RD: begin
                    if (MemGnt) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_data  <= MemRdData;
                    r_state <= S_WR;
                end
                S_WR: begin
                    if (MemGnt) begin
                        r_idx   <= w_idx_next;
                        r_state <= (w_idx_next == r_len) ? S_DONE : S_RD;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write/shift strobes follow MemGnt in the same cycle, so they are decoded here
    // from the registered state rather than registered themselves.
    always_comb begin
        Busy           = (r_state != S_IDLE);
        Done           = (r_state == S_DONE);
        LFSRSetState   = (r_state == S_CFG);
        LFSRSetTapPtrn = (r_state == S_CFG);
        LFSRShift      = 1'b0;
        MemWrEn        = 1'b0;
        MemAddr        = '0;
        MemWrData      = '0;
        case (r_state)
`ifdef CRYPT_PREAMBLE_EN
            S_PRE: begin
                MemAddr   = r_dst + ADDR_W'(r_pre_k);
                MemWrData = PRE_CHAR ^ {1'b0, LFSRState};
                MemWrEn   = MemGnt;
                LFSRShift = MemGnt;
            end
`endif
            S_RD: begin
                MemAddr = r_src + w_idx_a;
            end
            S_WR: begin
                MemAddr   = w_msg_dst + w_idx_a;
                MemWrData = r_data ^ {1'b0, LFSRState};
                MemWrEn   = MemGnt;
                LFSRShift = MemGnt;
            end
            default: begin
                MemAddr = '0;
            end
        endcase
    end

    assign LFSRSeedOut = r_seed;
    assign LFSRTapOut  = r_taps;

endmodule

// File: tb/tb_lfsr_crypt_seq.sv
// Self-checking bench for lfsr_crypt_seq: emulates the LFSR and data memory, and
// compares memory contents, strobes and timing against a sequence-level model.
module tb_lfsr_crypt_seq;

    localparam int unsigned PRE_LEN  = 10;
    localparam logic [7:0]  PRE_CHAR = 8'h20;
`ifdef CRYPT_PREAMBLE_EN
    localparam int P = PRE_LEN;
`else
    localparam int P = 0;
`endif
    localparam int BUDGET = 3000;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic [6:0] CfgSeed = '0;
    logic [6:0] CfgTaps = '0;
    logic [7:0] CfgSrc = '0;
    logic [7:0] CfgDst = '0;
    logic [7:0] CfgLen = '0;
    logic       MemGnt = 1'b1;
    logic [7:0] MemRdData;
    logic [6:0] LFSRState;
    logic       Busy, Done, LFSRSetState, LFSRSetTapPtrn, LFSRShift, MemWrEn;
    logic [6:0] LFSRSeedOut, LFSRTapOut;
    logic [7:0] MemAddr, MemWrData;

    lfsr_crypt_seq #(.ADDR_W(8), .PRE_LEN(PRE_LEN), .PRE_CHAR(PRE_CHAR)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .CfgSeed(CfgSeed), .CfgTaps(CfgTaps), .CfgSrc(CfgSrc), .CfgDst(CfgDst), .CfgLen(CfgLen),
        .MemGnt(MemGnt), .MemRdData(MemRdData), .LFSRState(LFSRState),
        .Busy(Busy), .Done(Done), .LFSRSetState(LFSRSetState), .LFSRSetTapPtrn(LFSRSetTapPtrn),
        .LFSRShift(LFSRShift), .LFSRSeedOut(LFSRSeedOut), .LFSRTapOut(LFSRTapOut),
        .MemAddr(MemAddr), .MemWrEn(MemWrEn), .MemWrData(MemWrData)
    );

    always #5 Clk = ~Clk;

    // External memory (1-cycle read latency) and LFSR emulation, plus strobe monitors.
    logic [7:0] mem [256];
    logic [7:0] img [256];
    logic [7:0] mdl [256];
    logic       ld_req = 1'b0;
    logic [6:0] lf_tap;
    int         n_shift = 0, n_wr = 0, n_bad = 0;

    always @(posedge Clk) begin
        if (ld_req) mem <= img;
        else if (MemWrEn) mem[MemAddr] <= MemWrData;
        MemRdData <= mem[MemAddr];
        if (LFSRSetState) LFSRState <= LFSRSeedOut;
        else if (LFSRShift) LFSRState <= {LFSRState[5:0], ^(LFSRState & lf_tap)};
        if (LFSRSetTapPtrn) lf_tap <= LFSRTapOut;
        if (LFSRShift) n_shift++;
        if (MemWrEn) n_wr++;
        if (LFSRShift != MemWrEn) n_bad++;
    end

    int n_chk = 0, n_pass = 0;
    int op_lat, op_shifts, op_writes, op_bad;
    logic [7:0] addr_log [64];
    logic       wr_log   [64];
    logic [6:0] seed_log [64];

    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] t);
        return {s[5:0], ^(s & t)};
    endfunction

    // Reference: the i-th output byte is the i-th input byte XOR the i-th LFSR state.
    task automatic model_run(input logic [6:0] seed, input logic [6:0] taps,
                             input logic [7:0] src, input logic [7:0] dst, input int len);
        logic [6:0] s;
        s = seed;
        for (int k = 0; k < P; k++) begin
            mdl[8'(int'(dst) + k)] = PRE_CHAR ^ {1'b0, s};
            s = lfsr_step(s, taps);
        end
        for (int j = 0; j < len; j++) begin
            mdl[8'(int'(dst) + P + j)] = mdl[8'(int'(src) + j)] ^ {1'b0, s};
            s = lfsr_step(s, taps);
        end
    endtask

    function automatic int count_diff(output int first);
        int n;
        n = 0;
        first = -1;
        for (int a = 0; a < 256; a++) begin
            if (mem[a] !== mdl[a]) begin
                if (first < 0) first = a;
                n++;
            end
        end
        return n;
    endfunction

    task automatic random_img();
        for (int a = 0; a < 256; a++) img[a] = 8'($urandom);
    endtask

    task automatic commit_img();
        for (int a = 0; a < 256; a++) mdl[a] = img[a];
        @(posedge Clk); #1;
        ld_req = 1'b1;
        @(posedge Clk); #1;
        ld_req = 1'b0;
    endtask

    // Launches one operation; cycle k is the k-th cycle after the Start-sampling edge.
    task automatic run_op(input logic [6:0] seed, input logic [6:0] taps,
                          input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len,
                          input logic [63:0] gnt_off, input int abort_k, input int restart_k);
        int s0, w0, b0;
        s0 = n_shift; w0 = n_wr; b0 = n_bad;
        @(posedge Clk); #1;
        CfgSeed = seed; CfgTaps = taps; CfgSrc = src; CfgDst = dst; CfgLen = len;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        op_lat = -1;
        for (int k = 1; k <= BUDGET; k++) begin
            MemGnt = (k < 64) ? !gnt_off[k] : 1'b1;
            if (k == abort_k) begin
                Reset = 1'b0;
                #1;
                break;
            end
            if (k == restart_k) begin
                Start = 1'b1;
                CfgSeed = ~seed; CfgTaps = ~taps;
                CfgSrc = src + 8'h11; CfgDst = dst + 8'h22; CfgLen = len + 8'd3;
            end
            @(negedge Clk);
            if (k < 64) begin
                addr_log[k] = MemAddr;
                wr_log[k]   = MemWrEn;
                seed_log[k] = LFSRSeedOut;
            end
            if (Done) op_lat = k;
            @(posedge Clk); #1;
            Start = 1'b0;
            if (op_lat >= 0) break;
        end
        MemGnt = 1'b1;
        op_shifts = n_shift - s0;
        op_writes = n_wr - w0;
        op_bad    = n_bad - b0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_chk++;
        if ({Busy, Done, LFSRSetState, LFSRSetTapPtrn, LFSRShift, MemWrEn, MemAddr, MemWrData,
             LFSRSeedOut, LFSRTapOut} !== 36'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b addr=%h seed=%h taps=%h, need all 0",
                     Busy, Done, MemAddr, LFSRSeedOut, LFSRTapOut);
        else n_pass++;
        Reset = 1'b1;
        @(posedge Clk); #1;
        n_chk++;
        if (Busy !== 1'b0) $display("FAIL reset_idle: Busy=%b need 0", Busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        int nd, fa;
        random_img();
        img[0] = 8'h41; img[1] = 8'h42;
        commit_img();
        model_run(7'h01, 7'h60, 8'h00, 8'h40, 2);
        run_op(7'h01, 7'h60, 8'h00, 8'h40, 8'd2, 64'd0, 0, 0);
        n_chk++;
        if (op_lat !== 8 + P) $display("FAIL basic_latency: got %0d need %0d", op_lat, 8 + P);
        else n_pass++;
        nd = count_diff(fa);
        n_chk++;
        if (nd !== 0) $display("FAIL basic_mem: %0d bad bytes, first at %0d got %h need %h",
                               nd, fa, mem[fa], mdl[fa]);
        else n_pass++;
`ifndef CRYPT_PREAMBLE_EN
        n_chk++;
        if ({mem[8'h40], mem[8'h41]} !== 16'h4040)
            $display("FAIL basic_bytes: got %h %h need 40 40", mem[8'h40], mem[8'h41]);
        else n_pass++;
`endif
        n_chk++;
        if (op_shifts !== P + 2) $display("FAIL basic_shifts: got %0d need %0d", op_shifts, P + 2);
        else n_pass++;
        n_chk++;
        if (op_bad !== 0) $display("FAIL basic_strobe_align: %0d cycles shift!=wren, need 0", op_bad);
        else n_pass++;
    endtask

    task automatic test_zero_len();
        int nd, fa;
        random_img();
        commit_img();
        model_run(7'h15, 7'h41, 8'h30, 8'h90, 0);
        run_op(7'h15, 7'h41, 8'h30, 8'h90, 8'd0, 64'd0, 0, 0);
        n_chk++;
        if (op_lat !== 2 + P) $display("FAIL zero_latency: got %0d need %0d", op_lat, 2 + P);
        else n_pass++;
        n_chk++;
        if (op_writes !== P || op_shifts !== P)
            $display("FAIL zero_strobes: writes=%0d shifts=%0d need %0d", op_writes, op_shifts, P);
        else n_pass++;
        nd = count_diff(fa);
        n_chk++;
        if (nd !== 0) $display("FAIL zero_mem: %0d bad bytes, first at %0d", nd, fa);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int nd, fa, bad;
        random_img();
        commit_img();
        model_run(7'h2A, 7'h71, 8'hFF, 8'hFE, 3);
        run_op(7'h2A, 7'h71, 8'hFF, 8'hFE, 8'd3, 64'd0, 0, 0);
        bad = 0;
        for (int j = 0; j < 3; j++) begin
            if (addr_log[2 + P + 3*j] !== 8'(255 + j)) bad++;
            if (addr_log[4 + P + 3*j] !== 8'(254 + P + j) || wr_log[4 + P + 3*j] !== 1'b1) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL wrap_addr: %0d wrong rd/wr addresses, first rd=%h need ff",
                                bad, addr_log[2 + P]);
        else n_pass++;
        nd = count_diff(fa);
        n_chk++;
        if (nd !== 0) $display("FAIL wrap_mem: %0d bad bytes, first at %0d got %h need %h",
                               nd, fa, mem[fa], mdl[fa]);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [63:0] off;
        int nd, fa, bad;
        off = '0;
        for (int k = 5 + P; k <= 8 + P; k++) off[k] = 1'b1;
        off[11 + P] = 1'b1;
        off[12 + P] = 1'b1;
        random_img();
        commit_img();
        model_run(7'h33, 7'h5C, 8'h10, 8'h80, 2);
        run_op(7'h33, 7'h5C, 8'h10, 8'h80, 8'd2, off, 0, 0);
        n_chk++;
        if (op_lat !== 14 + P) $display("FAIL stall_latency: got %0d need %0d", op_lat, 14 + P);
        else n_pass++;
        bad = 0;
        for (int k = 5 + P; k <= 9 + P; k++) if (addr_log[k] !== 8'h11) bad++;
        n_chk++;
        if (bad !== 0) $display("FAIL stall_addr_hold: %0d cycles off, got %h need 11", bad, addr_log[6 + P]);
        else n_pass++;
        n_chk++;
        if ({wr_log[11 + P], wr_log[12 + P], wr_log[13 + P]} !== 3'b001)
            $display("FAIL stall_wren: got %b%b%b need 001", wr_log[11 + P], wr_log[12 + P], wr_log[13 + P]);
        else n_pass++;
        nd = count_diff(fa);
        n_chk++;
        if (nd !== 0 || op_shifts !== P + 2)
            $display("FAIL stall_data: %0d bad bytes, shifts=%0d need 0 and %0d", nd, op_shifts, P + 2);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nd, fa, w_hold;
        random_img();
        commit_img();
        model_run(7'h4B, 7'h60, 8'h20, 8'hA0, 2);
        run_op(7'h4B, 7'h60, 8'h20, 8'hA0, 8'd5, 64'd0, 10 + P, 0);
        n_chk++;
        if ({Busy, Done, LFSRShift, MemWrEn, MemAddr, MemWrData, LFSRSeedOut, LFSRTapOut} !== 34'd0)
            $display("FAIL abort_outputs: busy=%b wren=%b addr=%h seed=%h need all 0",
                     Busy, MemWrEn, MemAddr, LFSRSeedOut);
        else n_pass++;
        w_hold = n_wr;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_chk++;
        if (op_writes !== P + 2 || n_wr !== w_hold)
            $display("FAIL abort_writes: got %0d (+%0d late) need %0d", op_writes, n_wr - w_hold, P + 2);
        else n_pass++;
        nd = count_diff(fa);
        n_chk++;
        if (nd !== 0 || Busy !== 1'b0)
            $display("FAIL abort_mem: %0d bad bytes (first %0d), Busy=%b need 0", nd, fa, Busy);
        else n_pass++;
    endtask

    task automatic test_start_busy();
        int nd, fa;
        random_img();
        commit_img();
        model_run(7'h09, 7'h48, 8'h60, 8'hC0, 3);
        run_op(7'h09, 7'h48, 8'h60, 8'hC0, 8'd3, 64'd0, 0, 3 + P);
        n_chk++;
        if (op_lat !== 11 + P || seed_log[4 + P] !== 7'h09)
            $display("FAIL busy_start: lat=%0d seed=%h need %0d and 09", op_lat, seed_log[4 + P], 11 + P);
        else n_pass++;
        @(posedge Clk); #1;
        nd = count_diff(fa);
        n_chk++;
        if (nd !== 0 || Busy !== 1'b0)
            $display("FAIL busy_start_mem: %0d bad bytes, Busy=%b need 0 and 0", nd, Busy);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0]  seed, taps;
        logic [7:0]  src, dst, len;
        logic [63:0] off;
        int nd, fa;
        for (int it = 0; it < 9; it++) begin
            seed = 7'($urandom_range(1, 127));
            taps = 7'($urandom);
            src  = 8'($urandom);
            dst  = (it == 8) ? src : 8'($urandom);
            len  = (it == 8) ? 8'd255 : 8'($urandom_range(0, 40));
            off  = (it % 2 == 1) ? {$urandom, $urandom} : 64'd0;
            random_img();
            commit_img();
            model_run(seed, taps, src, dst, int'(len));
            run_op(seed, taps, src, dst, len, off, 0, 0);
            nd = count_diff(fa);
            n_chk++;
            if (nd !== 0)
                $display("FAIL rand%0d_mem: len=%0d %0d bad bytes, first at %0d got %h need %h",
                         it, len, nd, fa, mem[fa], mdl[fa]);
            else n_pass++;
            n_chk++;
            if (op_shifts !== P + int'(len) || op_writes !== P + int'(len) || op_bad !== 0)
                $display("FAIL rand%0d_strobes: shifts=%0d writes=%0d misaligned=%0d need %0d %0d 0",
                         it, op_shifts, op_writes, op_bad, P + int'(len), P + int'(len));
            else n_pass++;
            n_chk++;
            if ((off == 64'd0) ? (op_lat !== 2 + P + 3 * int'(len)) : (op_lat < 2 + P + 3 * int'(len)))
                $display("FAIL rand%0d_latency: got %0d need %0d", it, op_lat, 2 + P + 3 * int'(len));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_wrap();
        test_stall();
        test_reset_mid();
        test_start_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, need completion");
        $fatal(1, "watchdog");
    end

endmodule
